// File: rtl/alarm_zone_sequencer.sv
// Multi-zone alarm sequencer: OFF -> ARMED -> ENTRY -> ALARM with round-robin zone grant.
// Optional build macro ALARM_INSTANT_ZONE0_EN: a zone 0 grant skips ENTRY and goes straight to ALARM.
module alarm_zone_sequencer #(
  parameter  int NZONES    = 4,
  parameter  int ENTRY_DLY = 16,
  parameter  int SIREN_CYC = 32,
  localparam int ZW        = (NZONES > 1) ? $clog2(NZONES) : 1,
  localparam int CW        = $clog2(((ENTRY_DLY > SIREN_CYC) ? ENTRY_DLY : SIREN_CYC) + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_req,
  input  logic              disarm_req,
  input  logic [NZONES-1:0] zone_trip,
  input  logic [NZONES-1:0] zone_mask,
  output logic [1:0]        state,
  output logic              siren,
  output logic [ZW-1:0]     active_zone,
  output logic              zone_valid,
  output logic [CW-1:0]     delay_cnt
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ARMED = 2'b01,
    ST_ENTRY = 2'b10,
    ST_ALARM = 2'b11
  } state_t;

  localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DLY - 1);
  localparam logic [CW-1:0] SIREN_LOAD = CW'(SIREN_CYC - 1);

  state_t            state_q;
  logic [ZW-1:0]     rr_ptr;
  logic [NZONES-1:0] eligible;
  logic [ZW-1:0]     grant;
  logic [ZW-1:0]     rr_next;
  logic              grant_hit;
  int                scan_idx;

  assign eligible = zone_trip & ~zone_mask;

  // Scan zones starting at rr_ptr, wrapping, and take the first eligible one.
  // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_hit = 1'b0;
    scan_idx  = 0;
    for (int i = 0; i < NZONES; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= NZONES) scan_idx = scan_idx - NZONES;
      if (!grant_hit && eligible[scan_idx]) begin
        grant     = ZW'(scan_idx);
        grant_hit = 1'b1;
      end
    end
  end

  assign rr_next = (grant == ZW'(NZONES - 1)) ? '0 : grant + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      active_zone <= '0;
      zone_valid  <= 1'b0;
      delay_cnt   <= '0;
      rr_ptr      <= '0;
    end else if (disarm_req) begin
      state_q    <= ST_OFF;
      zone_valid <= 1'b0;
      delay_cnt  <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (arm_req) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (grant_hit) begin
            active_zone <= grant;
            zone_valid  <= 1'b1;
            rr_ptr      <= rr_next;
`ifdef ALARM_INSTANT_ZONE0_EN
            if (grant == '0) begin
              state_q   <= ST_ALARM;
              delay_cnt <= SIREN_LOAD;
            end else begin
              state_q   <= ST_ENTRY;
              delay_cnt <= ENTRY_LOAD;
            end
`else
            state_q   <= ST_ENTRY;
            delay_cnt <= ENTRY_LOAD;
`endif
          end
        end
        ST_ENTRY: begin
          if (delay_cnt != '0) begin
            delay_cnt <= delay_cnt - 1'b1;
          end else begin
            state_q   <= ST_ALARM;
            delay_cnt <= SIREN_LOAD;
          end
        end
        ST_ALARM: begin
          // active_zone is kept after re-arm so status shows the last cause.
          if (delay_cnt != '0) begin
            delay_cnt <= delay_cnt - 1'b1;
          end else begin
            state_q    <= ST_ARMED;
            zone_valid <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_OFF;
          zone_valid <= 1'b0;
          delay_cnt  <= '0;
        end
      endcase
    end
  end

  // Siren is a decode of the state register, so an async reset silences it at once.
  assign state = state_q;
  assign siren = (state_q == ST_ALARM);

endmodule

// File: tb/tb_alarm_zone_sequencer.sv
// Directed self-checking bench for alarm_zone_sequencer at default parameters.
module tb_alarm_zone_sequencer;

  localparam int NZONES = 4;
  localparam int ZW     = 2;
  localparam int CW     = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              arm_req;
  logic              disarm_req;
  logic [NZONES-1:0] zone_trip;
  logic [NZONES-1:0] zone_mask;
  logic [1:0]        state;
  logic              siren;
  logic [ZW-1:0]     active_zone;
  logic              zone_valid;
  logic [CW-1:0]     delay_cnt;

  int n_checks = 0;
  int n_errors = 0;

  alarm_zone_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm_req     (arm_req),
    .disarm_req  (disarm_req),
    .zone_trip   (zone_trip),
    .zone_mask   (zone_mask),
    .state       (state),
    .siren       (siren),
    .active_zone (active_zone),
    .zone_valid  (zone_valid),
    .delay_cnt   (delay_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [1:0] exp_state);
    check({tag, ".state"}, 32'(state), 32'(exp_state));
    check({tag, ".siren"}, 32'(siren), 32'(exp_state == 2'b11));
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    arm_req    = 1'b0;
    disarm_req = 1'b0;
    zone_trip  = '0;
    zone_mask  = '0;
    step(2);
    check_st("reset", 2'b00);
    check("reset.zone_valid", 32'(zone_valid), 0);
    check("reset.delay_cnt", 32'(delay_cnt), 0);
    check("reset.active_zone", 32'(active_zone), 0);
    rst_n = 1'b1;

    // Arm
    arm_req = 1'b1;
    step(1);
    check_st("arm", 2'b01);
    arm_req = 1'b0;

    // Trip zone 2: ENTRY after 1 edge, ALARM after 17, ARMED after 49
    zone_trip = 4'b0100;
    step(1);
    check_st("t2.entry", 2'b10);
    check("t2.active_zone", 32'(active_zone), 2);
    check("t2.zone_valid", 32'(zone_valid), 1);
    check("t2.delay_cnt", 32'(delay_cnt), 15);
    zone_trip = '0;
    step(15);
    check_st("t2.entry_last", 2'b10);
    check("t2.cnt_zero", 32'(delay_cnt), 0);
    step(1);
    check_st("t2.alarm", 2'b11);
    check("t2.siren_cnt", 32'(delay_cnt), 31);
    step(31);
    check_st("t2.alarm_last", 2'b11);
    step(1);
    check_st("t2.rearm", 2'b01);
    check("t2.rearm_valid", 32'(zone_valid), 0);
    check("t2.rearm_zone", 32'(active_zone), 2);
    step(3);
    check_st("t2.idle_armed", 2'b01);

    // arm_req outside OFF has no effect
    arm_req = 1'b1;
    step(2);
    check_st("arm_in_armed", 2'b01);
    arm_req = 1'b0;

    // Reset mid-ALARM: zone 2 again (rr_ptr=3 wraps to 2)
    zone_trip = 4'b0100;
    step(1);
    check("t1.grant", 32'(active_zone), 2);
    zone_trip = '0;
    step(16);
    check_st("t1.alarm", 2'b11);
    rst_n = 1'b0;
    #1;
    check_st("t1.async_reset", 2'b00);
    check("t1.valid", 32'(zone_valid), 0);
    step(1);
    rst_n = 1'b1;
    step(4);
    check_st("t1.stay_off", 2'b00);
    check("t1.cnt", 32'(delay_cnt), 0);

    // Round-robin with zones 1 and 3 held, rr_ptr=0 after reset
    arm_req = 1'b1;
    step(1);
    arm_req = 1'b0;
    check_st("t3.armed", 2'b01);
    zone_trip = 4'b1010;
    step(1);
    check_st("t3.entry1", 2'b10);
    check("t3.grant1", 32'(active_zone), 1);
    step(48);
    check_st("t3.rearm1", 2'b01);
    check("t3.rearm1_valid", 32'(zone_valid), 0);
    step(1);
    check_st("t3.entry2", 2'b10);
    check("t3.grant2", 32'(active_zone), 3);
    step(48);
    check_st("t3.rearm2", 2'b01);
    step(1);
    check("t3.grant3", 32'(active_zone), 1);

    // Disarm in ENTRY with delay_cnt=5
    step(10);
    check("t5.cnt5", 32'(delay_cnt), 5);
    check_st("t5.in_entry", 2'b10);
    disarm_req = 1'b1;
    step(1);
    check_st("t5.disarm", 2'b00);
    check("t5.cnt", 32'(delay_cnt), 0);
    check("t5.valid", 32'(zone_valid), 0);
    arm_req = 1'b1;
    step(2);
    check_st("t5.arm_and_disarm", 2'b00);
    arm_req    = 1'b0;
    disarm_req = 1'b0;
    zone_trip  = '0;

    // Masked zone 1 is ignored until unmasked (rr_ptr=2)
    arm_req = 1'b1;
    step(1);
    arm_req   = 1'b0;
    zone_mask = 4'b0010;
    zone_trip = 4'b0010;
    step(20);
    check_st("t4.masked", 2'b01);
    check("t4.masked_valid", 32'(zone_valid), 0);
    zone_mask = 4'b0000;
    step(1);
    check_st("t4.unmask", 2'b10);
    check("t4.grant", 32'(active_zone), 1);
    zone_mask = 4'b1111;
    step(3);
    check_st("t4.mask_mid_entry", 2'b10);
    check("t4.hold_valid", 32'(zone_valid), 1);
    check("t4.cnt", 32'(delay_cnt), 12);
    disarm_req = 1'b1;
    step(1);
    disarm_req = 1'b0;
    zone_trip  = '0;
    zone_mask  = '0;
    check_st("t4.disarm", 2'b00);

    // Zone 0 trip (rr_ptr=2, wraps to 0)
    arm_req = 1'b1;
    step(1);
    arm_req   = 1'b0;
    zone_trip = 4'b0001;
    step(1);
    zone_trip = '0;
    check("t6.grant", 32'(active_zone), 0);
`ifdef ALARM_INSTANT_ZONE0_EN
    check_st("t6.instant_alarm", 2'b11);
    check("t6.cnt", 32'(delay_cnt), 31);
`else
    check_st("t6.entry", 2'b10);
    step(15);
    check_st("t6.pre_alarm", 2'b10);
    step(1);
    check_st("t6.alarm", 2'b11);
    check("t6.cnt", 32'(delay_cnt), 31);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
